// File: rtl/twowire_host_serial_comms.sv
// Host-side serial engine for Two-Wire Debug.
// Takes one command request at a time, serialises it onto DIO as
// start / cmd / cmd parity / turnaround / data / data parity / tail, and
// returns captured read data with a parity-error flag.
// DI arrives already registered by the pad; DO/DOE are produced one cycle
// ahead (do_nxt/doe_nxt) so the pad can register them.
//
// Request handshake: a request transfers on a rising dck edge where both
// req_vld and req_rdy are high. req_rdy is high only while the engine is idle
// and out of reset. The requester must hold req_cmd/req_len/req_wdata stable
// while req_vld is high and not yet accepted. The req_* inputs are ignored
// at all other times. resp_vld is a single-cycle pulse with no back-pressure.
module twowire_host_serial_comms #(
  parameter int W_CMD  = 4,
  parameter int W_DATA = 32,
  parameter int W_LEN  = 5
) (
  input  logic              dck,
  input  logic              drst_n,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic [W_CMD-1:0]  req_cmd,
  input  logic [W_LEN-1:0]  req_len,
  input  logic [W_DATA-1:0] req_wdata,
  output logic              resp_vld,
  output logic [W_DATA-1:0] resp_rdata,
  output logic              resp_perr,
  input  logic              di_q,
  output logic              do_nxt,
  output logic              doe_nxt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_TURN = 3'd2,
    S_DATA = 3'd3,
    S_DPAR = 3'd4,
    S_TAIL = 3'd5
  } state_t;

  // Last in-state count for the fixed-length states.
  localparam logic [W_LEN:0] HDR_LAST  = (W_LEN+1)'(5);
  localparam logic [W_LEN:0] TURN_LAST = (W_LEN+1)'(1);
  localparam logic [W_LEN:0] TAIL_LAST = (W_LEN+1)'(1);
  // Largest payload index, used to build the length mask.
  localparam logic [W_LEN:0] DMAX      = (W_LEN+1)'(W_DATA-1);

  state_t              state, state_nxt;
  logic [W_LEN:0]      cnt, cnt_nxt;

  logic [W_CMD-1:0]    cmd_q;
  logic [W_LEN-1:0]    len_q;
  logic [W_DATA-1:0]   wdata_q;
  logic                is_write;
  logic [W_DATA-1:0]   rdata_q;

  // Read capture pipeline: di_q lags do_nxt slots by two cycles, so the
  // S_DATA slot index is delayed two stages before it selects the bit.
  logic                rx_v1, rx_v2;
  logic [W_LEN-1:0]    rx_i1, rx_i2;

  logic                accept;
  logic                do_bit, doe_bit;
  logic [W_LEN:0]      mask_shift;
  logic [W_DATA-1:0]   len_mask;
  logic                frame_end;

  assign req_rdy    = drst_n && (state == S_IDLE);
  assign accept     = req_vld && req_rdy;
  // Keep only bits [L-1:0] of the write payload so parity covers just L bits.
  assign mask_shift = DMAX - {1'b0, req_len};
  assign len_mask   = {W_DATA{1'b1}} >> mask_shift;
  // Last tail slot: the read parity bit from the target is on di_q now.
  assign frame_end  = (state == S_TAIL) && (cnt == TAIL_LAST);

  // Pad outputs are forced low/released while reset is asserted.
  assign do_nxt  = drst_n ? do_bit  : 1'b0;
  assign doe_nxt = drst_n ? doe_bit : 1'b0;

  // Next-state, in-state counter and next-cycle DIO drive.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    do_bit    = 1'b0;
    doe_bit   = 1'b1;
    case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (accept) state_nxt = S_HDR;
      end
      S_HDR: begin
        case (cnt[2:0])
          3'd0:    do_bit = 1'b1;
          3'd1:    do_bit = cmd_q[3];
          3'd2:    do_bit = cmd_q[2];
          3'd3:    do_bit = cmd_q[1];
          3'd4:    do_bit = cmd_q[0];
          default: do_bit = ~^cmd_q;
        endcase
        if (cnt == HDR_LAST) begin
          state_nxt = S_TURN;
          cnt_nxt   = '0;
        end
      end
      S_TURN: begin
        doe_bit = is_write;
        if (cnt == TURN_LAST) begin
          state_nxt = S_DATA;
          cnt_nxt   = '0;
        end
      end
      S_DATA: begin
        doe_bit = is_write;
        do_bit  = is_write & wdata_q[cnt[W_LEN-1:0]];
        if (cnt == {1'b0, len_q}) begin
          state_nxt = S_DPAR;
          cnt_nxt   = '0;
        end
      end
      S_DPAR: begin
        doe_bit   = is_write;
        do_bit    = is_write & ~(^wdata_q);
        state_nxt = S_TAIL;
        cnt_nxt   = '0;
      end
      S_TAIL: begin
        doe_bit = is_write;
        if (cnt == TAIL_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register, request latch, read capture and response registers.
  always_ff @(posedge dck) begin
    if (!drst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      cmd_q      <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      is_write   <= 1'b0;
      rdata_q    <= '0;
      rx_v1      <= 1'b0;
      rx_v2      <= 1'b0;
      rx_i1      <= '0;
      rx_i2      <= '0;
      resp_vld   <= 1'b0;
      resp_rdata <= '0;
      resp_perr  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;

      if (accept) begin
        cmd_q    <= req_cmd;
        len_q    <= req_len;
        wdata_q  <= req_wdata & len_mask;
        is_write <= ~^req_cmd;
        rdata_q  <= '0;
      end

      rx_v1 <= (state == S_DATA) && !is_write;
      rx_i1 <= cnt[W_LEN-1:0];
      rx_v2 <= rx_v1;
      rx_i2 <= rx_i1;
      if (rx_v2) rdata_q[rx_i2] <= di_q;

      resp_vld <= frame_end;
      if (frame_end) begin
        resp_rdata <= is_write ? '0 : rdata_q;
        resp_perr  <= !is_write && (di_q != ~(^rdata_q));
      end
    end
  end

endmodule

// File: doc/twowire_host_serial_comms.md
# twowire_host_serial_comms

Host-side serial engine for Two-Wire Debug. It accepts one command request at a time: a 4-bit command, a payload length and write data. It serialises the request onto DIO as a frame (start bit, command, command parity, turnaround, data, data parity, tail) and returns captured read data with a parity-error flag. It is the initiator counterpart of the DTM-side serial unit and drives the same pad register arrangement: registered DI in, and DO/DOE computed one cycle ahead.

## Interface
Parameters:
- W_CMD, 4: command width. Only 4 is supported.
- W_DATA, 32: maximum payload bits.
- W_LEN, 5: width of req_len, equal to clog2(W_DATA).

Ports:
- dck  in  1  clock; all logic is on the posedge.
- drst_n  in  1  reset; synchronous, active-low.
- req_vld  in  1  request valid.
- req_rdy  out  1  request ready; high only in S_IDLE.
- req_cmd  in  W_CMD  command; direction is derived from it.
- req_len  in  W_LEN  payload length minus 1, so L = req_len + 1.
- req_wdata  in  W_DATA  write payload, sent LSB first.
- resp_vld  out  1  one-cycle completion pulse.
- resp_rdata  out  W_DATA  read payload; bits at index L and above are 0.
- resp_perr  out  1  read data parity mismatch; valid with resp_vld.
- di_q  in  1  DIO input, already registered by the pad.
- do_nxt  out  1  DIO output value for the next cycle.
- doe_nxt  out  1  DIO output enable for the next cycle.

## Operation
- Acceptance: a request is accepted when req_vld && req_rdy. The engine latches req_cmd, L, req_wdata and is_write = ~^req_cmd; is_write is 1 when the command has an even number of ones.
- Cycle numbering: c0 is the cycle after acceptance. Values are given on do_nxt/doe_nxt.
- States: S_IDLE → S_HDR (c0..c5) → S_TURN (c6..c7) → S_DATA (c8..c7+L) → S_DPAR (c8+L) → S_TAIL (c9+L..c10+L) → S_IDLE (c11+L).
- S_IDLE: doe=1, do=0 (park low).
- S_HDR:
  - c0: start bit, do=1.
  - c1..c4: req_cmd[3], [2], [1], [0].
  - c5: ~^req_cmd.
  - doe=1 throughout.
- Write frame:
  - S_TURN: doe=1, do=0.
  - S_DATA: do = wdata[c-8].
  - S_DPAR: do = 1 ^ (^wdata[L-1:0]).
  - S_TAIL: do=0.
  - doe=1 in every write state.
- Read frame:
  - doe=0 from c6 through c10+L.
  - Capture di_q into rdata[c-10] for c10..c9+L.
  - Compute expected parity = 1 ^ (^rdata[L-1:0]).
  - Compare it against di_q at c10+L.
- Completion, at c11+L (the engine is in S_IDLE):
  - resp_vld=1.
  - Read: resp_perr = mismatch, and resp_rdata holds the captured data.
  - Write: resp_perr=0, and resp_rdata=0.
  - resp_rdata/resp_perr hold until the next completion.
- Counter: a W_LEN+1 bit cycle counter within each state. Boundary cases:
  - L=1 (req_len=0) is a legal single data cycle.
  - L=W_DATA uses the full width with no wrap.
- Reset mid-frame: on the clock edge with drst_n low the engine goes to S_IDLE and drops the frame. No resp_vld is issued. The target times out through its own tail states and sees only park-low.
- Reset outputs: while drst_n is low, do_nxt=0, doe_nxt=0 and req_rdy=0 are forced combinationally.
- Registers after reset: resp_vld=0, resp_rdata=0, resp_perr=0.

## Timing
- Latency from acceptance to resp_vld: L+12 cycles.
- req_rdy rises in the resp_vld cycle.
- Back-to-back requests: the frame period is L+12 cycles, with the start bit at c0 of each frame.
- Wire slots lag do_nxt by one cycle, and di_q lags the wire by one cycle.
- Read turnaround:
  - The target first drives data in slot c8.
  - The target releases DIO after c9+L.
  - The host redrives no earlier than c11+L, leaving 1 undriven slot.
- The tail gives the target 2 slots of park-low before the next start bit.
- The req_* inputs are sampled only at acceptance. Changes during a frame are ignored.

## Test plan
1. Write, req_cmd=4'h3, L=32, wdata=32'h12345678.
   - Required do_nxt: c0=1; c1..c4=0,0,1,1; c5=1; c6..c7=0; c8..c39 = wdata LSB first; c40=0; c41..c42=0.
   - Required: doe_nxt=1 throughout; resp_vld at c43 with perr=0 and rdata=0.
2. Read, req_cmd=4'h1, L=8. The bench models the DTM, driving 8'hA5 LSB first in slots c8..c15 and parity 1 in slot c16.
   - Required: c5 parity=0; doe_nxt=0 for c6..c18; resp_vld at c19 with rdata=32'hA5 and perr=0.
3. Same as 2, with the parity slot driven 0 -> resp_perr=1, rdata=32'hA5.
4. req_vld held high with two writes of L=4 -> the second start bit comes 16 cycles after the first, and req_rdy is high only in the resp_vld cycles.
5. Assert drst_n low for one cycle at c20 of scenario 1.
   - Required during reset: doe_nxt=0 and req_rdy=0.
   - Required afterwards: no resp_vld; S_IDLE park-low (doe=1, do=0); a fresh request completes normally.
6. Loopback against the DTM-side serial unit, random cmd/len/data over 1000 frames -> zero parity errors on either side, and read data matches the target model.
